// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of NUM_PORTS output ports plus one synchronised input port.
// Define MMIO_PORT_IRQ_EN to add rising-edge status/mask registers and the irq output.
module mmio_port_bank #(
    parameter logic [15:0] BASE_ADDR = 16'h8400,
    parameter int          NUM_PORTS = 4,
    parameter int          PORT_W    = 8,
    parameter logic [7:0]  OUT_RESET = 8'h00
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 cpu_addr,
    input  logic [7:0]                  cpu_data_out,
    input  logic                        cpu_writing,
    input  logic                        cpu_clk,
    output logic [NUM_PORTS*PORT_W-1:0] io_port,
    output logic [NUM_PORTS-1:0]        port_wr,
    input  logic [PORT_W-1:0]           in_pins,
    output logic [7:0]                  rd_data,
    output logic                        rd_hit
`ifdef MMIO_PORT_IRQ_EN
    ,
    output logic                        irq
`endif
);

    function automatic logic [7:0] zext(input logic [PORT_W-1:0] v);
        logic [7:0] r;
        r = 8'h00;
        r[PORT_W-1:0] = v;
        return r;
    endfunction

    logic                        hit_s;
    logic [3:0]                  off_s;
    logic                        wq_s;
    logic                        commit_s;
    logic                        wq_d_r;
    logic                        arm_r;
    logic [NUM_PORTS*PORT_W-1:0] io_port_r;
    logic [NUM_PORTS-1:0]        port_wr_r;
    logic [PORT_W-1:0]           s1_r;
    logic [PORT_W-1:0]           s2_r;
    logic [7:0]                  rd_mux_s;
    logic [7:0]                  rd_data_r;
    logic                        rd_hit_r;

    assign hit_s = (cpu_addr[15:4] == BASE_ADDR[15:4]);
    assign off_s = cpu_addr[3:0];
    assign wq_s  = cpu_writing & ~cpu_clk & hit_s;
    // arm_r blocks a commit from a wq that was already high when reset released
    assign commit_s = wq_s & ~wq_d_r & arm_r;

    // Write-qualifier edge tracking and re-arm after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_d_r <= 1'b0;
            arm_r  <= 1'b0;
        end else begin
            wq_d_r <= wq_s;
            arm_r  <= arm_r | ~wq_s;
        end
    end

    // Output port registers and one-cycle write strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_port_r <= {NUM_PORTS{OUT_RESET[PORT_W-1:0]}};
            port_wr_r <= {NUM_PORTS{1'b0}};
        end else begin
            port_wr_r <= {NUM_PORTS{1'b0}};
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (commit_s && (off_s == 4'(k))) begin
                    io_port_r[k*PORT_W +: PORT_W] <= cpu_data_out[PORT_W-1:0];
                    port_wr_r[k]                  <= 1'b1;
                end
            end
        end
    end

    // Two-flop input synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r <= {PORT_W{1'b0}};
            s2_r <= {PORT_W{1'b0}};
        end else begin
            s1_r <= in_pins;
            s2_r <= s1_r;
        end
    end

`ifdef MMIO_PORT_IRQ_EN
    logic [PORT_W-1:0] s3_r;
    logic [PORT_W-1:0] status_r;
    logic [PORT_W-1:0] mask_r;
    logic              irq_r;
    logic [PORT_W-1:0] rise_s;
    logic [PORT_W-1:0] clr_s;

    // Edge detect and write-1-to-clear decode
    always_comb begin
        rise_s = s2_r & ~s3_r;
        if (commit_s && (off_s == 4'h9)) begin
            clr_s = cpu_data_out[PORT_W-1:0];
        end else begin
            clr_s = {PORT_W{1'b0}};
        end
    end

    // Status (set wins over clear), mask and registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_r     <= {PORT_W{1'b0}};
            status_r <= {PORT_W{1'b0}};
            mask_r   <= {PORT_W{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            s3_r     <= s2_r;
            status_r <= (status_r & ~clr_s) | rise_s;
            if (commit_s && (off_s == 4'hA)) begin
                mask_r <= cpu_data_out[PORT_W-1:0];
            end
            irq_r    <= |(status_r & mask_r);
        end
    end

    assign irq = irq_r;
`endif

    // Read data selection for the current offset
    always_comb begin
        rd_mux_s = 8'h00;
        case (off_s)
            4'h8: rd_mux_s = zext(s2_r);
`ifdef MMIO_PORT_IRQ_EN
            4'h9: rd_mux_s = zext(status_r);
            4'hA: rd_mux_s = zext(mask_r);
`endif
            default: begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    rd_mux_s = (off_s == 4'(k)) ? zext(io_port_r[k*PORT_W +: PORT_W]) : rd_mux_s;
                end
            end
        endcase
    end

    // Registered read port; zero outside the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r <= 8'h00;
            rd_hit_r  <= 1'b0;
        end else begin
            rd_data_r <= hit_s ? rd_mux_s : 8'h00;
            rd_hit_r  <= hit_s;
        end
    end

    assign io_port = io_port_r;
    assign port_wr = port_wr_r;
    assign rd_data = rd_data_r;
    assign rd_hit  = rd_hit_r;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Scoreboard bench for mmio_port_bank with default parameters; irq checks follow MMIO_PORT_IRQ_EN.
module tb_mmio_port_bank;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_writing;
    logic        cpu_clk;
    logic [31:0] io_port;
    logic [3:0]  port_wr;
    logic [7:0]  in_pins;
    logic [7:0]  rd_data;
    logic        rd_hit;
`ifdef MMIO_PORT_IRQ_EN
    logic        irq;
`endif

    mmio_port_bank dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_writing  (cpu_writing),
        .cpu_clk      (cpu_clk),
        .io_port      (io_port),
        .port_wr      (port_wr),
        .in_pins      (in_pins),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit)
`ifdef MMIO_PORT_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks_total  = 0;
    int checks_passed = 0;
    int pw_cnt[4]     = '{0, 0, 0, 0};
    int pw_snap[4];

    // Count port_wr pulses shortly after each active edge
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (port_wr[k] === 1'b1) pw_cnt[k]++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_item_t it;
        if (sb_q.size() != 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, got, it.exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap_pw();
        for (int k = 0; k < 4; k++) pw_snap[k] = pw_cnt[k];
    endtask

    // Expected pulse counts per port since the last snapshot
    task automatic check_pw(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            sb_push($sformatf("%s_pw%0d", tag, k), 32'(e[k]));
            sb_pop(32'(pw_cnt[k] - pw_snap[k]));
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        cpu_addr     = a;
        cpu_data_out = d;
        cpu_writing  = 1'b1;
        cyc(hold);
        cpu_writing  = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        cpu_addr     = 16'h0000;
        cpu_data_out = 8'h00;
        cpu_writing  = 1'b0;
        cpu_clk      = 1'b0;
        in_pins      = 8'h00;
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // Reset state
        sb_push("rst_io", 32'h0000_0000);
        sb_push("rst_rd", 32'h00);
        sb_push("rst_pw", 32'h0);
        sb_push("rst_hit", 32'h0);
        sb_pop(io_port);
        sb_pop({24'h0, rd_data});
        sb_pop({28'h0, port_wr});
        sb_pop({31'h0, rd_hit});

        // Sustained write to port 1 commits once
        snap_pw();
        cpu_addr = 16'h8401; cpu_data_out = 8'hA5; cpu_writing = 1'b1;
        sb_push("w1_io", 32'h0000_A500);
        sb_push("w1_pw", 32'h2);
        cyc(1);
        sb_pop(io_port);
        sb_pop({28'h0, port_wr});
        sb_push("w1_pw_drop", 32'h0);
        cyc(1);
        sb_pop({28'h0, port_wr});
        cyc(4);
        cpu_writing = 1'b0;
        cyc(1);
        check_pw("w1", 0, 1, 0, 0);
        sb_push("w1_rd", 32'hA5);
        sb_push("w1_hit", 32'h1);
        cyc(1);
        sb_pop({24'h0, rd_data});
        sb_pop({31'h0, rd_hit});

        // cpu_clk high blocks the write; lowering it commits once
        snap_pw();
        cpu_addr = 16'h8400; cpu_data_out = 8'h5A; cpu_clk = 1'b1; cpu_writing = 1'b1;
        cyc(3);
        sb_push("cclk_blocked_io", 32'h0000_A500);
        sb_pop(io_port);
        cpu_clk = 1'b0;
        cyc(1);
        sb_push("cclk_low_io", 32'h0000_A55A);
        sb_pop(io_port);
        cyc(2);
        cpu_writing = 1'b0;
        cyc(1);
        check_pw("cclk", 1, 0, 0, 0);

        // Out-of-window and unmapped-offset writes are ignored
        snap_pw();
        bus_write(16'h8410, 8'hFF, 2);
        sb_push("miss_rd", 32'h00);
        sb_push("miss_hit", 32'h0);
        sb_pop({24'h0, rd_data});
        sb_pop({31'h0, rd_hit});
        bus_write(16'h8404, 8'hFF, 2);
        sb_push("off4_rd", 32'h00);
        sb_push("off4_hit", 32'h1);
        sb_push("off4_io", 32'h0000_A55A);
        sb_pop({24'h0, rd_data});
        sb_pop({31'h0, rd_hit});
        sb_pop(io_port);
        check_pw("ign", 0, 0, 0, 0);

        // Input synchroniser latency
        cpu_addr = 16'h8408;
        in_pins  = 8'h81;
        cyc(2);
        sb_push("in_e2", 32'h00);
        sb_pop({24'h0, rd_data});
        cyc(1);
        sb_push("in_e3", 32'h81);
        sb_pop({24'h0, rd_data});
        cyc(1);
        sb_push("in_e4", 32'h81);
        sb_pop({24'h0, rd_data});

`ifdef MMIO_PORT_IRQ_EN
        // Status, mask, irq and write-1-to-clear
        bus_write(16'h840A, 8'h01, 1);
        cpu_addr = 16'h8409;
        cyc(1);
        sb_push("status_81", 32'h81);
        sb_push("irq_on", 32'h1);
        sb_pop({24'h0, rd_data});
        sb_pop({31'h0, irq});
        cpu_addr = 16'h840A;
        cyc(1);
        sb_push("mask_01", 32'h01);
        sb_pop({24'h0, rd_data});
        bus_write(16'h8409, 8'h01, 1);
        sb_push("w1c_status", 32'h80);
        sb_push("w1c_irq", 32'h0);
        sb_pop({24'h0, rd_data});
        sb_pop({31'h0, irq});

        // Edge and clear on bit 7 in the same cycle: set wins
        in_pins = 8'h01;
        cyc(3);
        bus_write(16'h8409, 8'h80, 1);
        sb_push("clr_status", 32'h00);
        sb_pop({24'h0, rd_data});
        in_pins = 8'h81;
        cpu_addr = 16'h8409; cpu_data_out = 8'h80;
        cyc(2);
        cpu_writing = 1'b1;
        cyc(1);
        cpu_writing = 1'b0;
        cyc(1);
        sb_push("set_wins", 32'h80);
        sb_pop({24'h0, rd_data});
`else
        cpu_addr = 16'h8409;
        cyc(1);
        sb_push("noirq_rd9", 32'h00);
        sb_pop({24'h0, rd_data});
        bus_write(16'h840A, 8'h01, 1);
        sb_push("noirq_rdA", 32'h00);
        sb_pop({24'h0, rd_data});
`endif

        // Reset between wq rise and the next edge
        snap_pw();
        cpu_addr = 16'h8402; cpu_data_out = 8'h33; cpu_writing = 1'b1;
        #2 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        sb_push("rstw_io", 32'h0000_0000);
        sb_pop(io_port);
        check_pw("rstw", 0, 0, 0, 0);
        cpu_writing = 1'b0;
        cyc(1);
        cpu_writing = 1'b1;
        cyc(1);
        sb_push("rstw_retry_io", 32'h0033_0000);
        sb_pop(io_port);
        cyc(1);
        cpu_writing = 1'b0;
        cyc(1);
        check_pw("rstw_retry", 0, 0, 1, 0);

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
